// File: rtl/tx_dispatch.sv
// rtl/tx_dispatch.sv - router TX stage: pops the flit FIFO, resolves the route, hands the flit to one of five ports
// Optional feature: define TX_DROP_CNT_EN to add the saturating drop_count port.
`ifndef SIZE
`define SIZE 8
`endif
`ifndef BITS_DIR
`define BITS_DIR 3
`endif

module tx_dispatch #(
    parameter int id = -1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    output logic                 fifo_read,
    input  logic [`SIZE-1:0]     fifo_data_out,
    output logic [`SIZE-1:0]     table_addr,
    input  logic [`BITS_DIR-1:0] table_data,
    output logic [4:0]           fifo_pop_req,
    input  logic [4:0]           fifo_pop_ack,
    output logic [5*`SIZE-1:0]   fifo_pop_data
`ifdef TX_DROP_CNT_EN
    ,
    output logic [7:0]           drop_count
`endif
);

    localparam int W  = `SIZE;
    localparam int BW = `BITS_DIR;
    localparam logic [BW-1:0] NUM_PORTS = BW'(5);

    // -1 is the "unassigned" sentinel; anything lower is a configuration error.
    if (id < -1) begin : g_id_check
        $error("tx_dispatch: id must be >= -1");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        LOOKUP = 3'd3,
        REQ    = 3'd4,
        REL    = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    flit_q, flit_d;
    logic [BW-1:0]   dir_q, dir_d;
    logic [4:0]      sel_oh;
    logic            ack_hit;
    logic            code_valid;
    logic            drop_evt;

    always_comb begin
        sel_oh = '0;
        for (int k = 0; k < 5; k++) begin
            sel_oh[k] = (dir_q == BW'(k));
        end
    end

    // Only the acknowledge of the selected port matters; the rest are ignored.
    assign ack_hit    = |(fifo_pop_ack & sel_oh);
    assign code_valid = (table_data < NUM_PORTS);
    assign drop_evt   = (state_q == LOOKUP) && !code_valid;

    always_comb begin
        state_d = state_q;
        flit_d  = flit_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = POP;
                end
            end
            POP: begin
                state_d = LOAD;
            end
            LOAD: begin
                flit_d  = fifo_data_out;
                state_d = LOOKUP;
            end
            LOOKUP: begin
                dir_d   = table_data;
                state_d = code_valid ? REQ : IDLE;
            end
            REQ: begin
                if (ack_hit) begin
                    state_d = REL;
                end
            end
            REL: begin
                if (!ack_hit) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            flit_q  <= '0;
            dir_q   <= '0;
        end else begin
            state_q <= state_d;
            flit_q  <= flit_d;
            dir_q   <= dir_d;
        end
    end

    // Moore outputs: data stays on the selected slice through REQ and REL.
    always_comb begin
        fifo_read     = (state_q == POP);
        table_addr    = flit_q;
        fifo_pop_req  = (state_q == REQ) ? sel_oh : 5'b0;
        fifo_pop_data = '0;
        for (int k = 0; k < 5; k++) begin
            if (((state_q == REQ) || (state_q == REL)) && sel_oh[k]) begin
                fifo_pop_data[k*W +: W] = flit_q;
            end
        end
    end

`ifdef TX_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_evt && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            if (drop_evt) begin
                $display("router %0d: dropped %h", id, flit_q);
            end
        end
    end

    assign drop_count = drop_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = drop_evt;
`endif

endmodule

// File: tb/tb_tx_dispatch.sv
// tb/tb_tx_dispatch.sv - self-checking bench for tx_dispatch against a transaction-level model
`ifndef SIZE
`define SIZE 8
`endif
`ifndef BITS_DIR
`define BITS_DIR 3
`endif

module tb_tx_dispatch;

    localparam int SZ = `SIZE;
    localparam int BW = `BITS_DIR;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              fifo_empty = 1'b1;
    logic              fifo_read;
    logic [SZ-1:0]     fifo_data_out = '0;
    logic [SZ-1:0]     table_addr;
    logic [BW-1:0]     table_data;
    logic [4:0]        fifo_pop_req;
    logic [4:0]        fifo_pop_ack = '0;
    logic [5*SZ-1:0]   fifo_pop_data;
`ifdef TX_DROP_CNT_EN
    logic [7:0]        drop_count;
`endif

    tx_dispatch #(.id(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .fifo_empty    (fifo_empty),
        .fifo_read     (fifo_read),
        .fifo_data_out (fifo_data_out),
        .table_addr    (table_addr),
        .table_data    (table_data),
        .fifo_pop_req  (fifo_pop_req),
        .fifo_pop_ack  (fifo_pop_ack),
        .fifo_pop_data (fifo_pop_data)
`ifdef TX_DROP_CNT_EN
        ,
        .drop_count    (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", nm, act, exp);
        end
    endtask

    // Environment: routing table, FIFO contents, port responders.
    logic [BW-1:0] tbl [256];
    assign table_data = tbl[table_addr];
    logic [SZ-1:0] fifo_q [$];
    int            ack_delay = 1;
    bit            hold_ack  = 0;
    logic [4:0]    glitch_req = '0;
    logic [4:0]    ack_r = '0;
    int            req_cnt [5];

    // Logs of observed events.
    int            cyc = 0;
    int            rd_cyc [$];
    int            req_cyc [$];
    int            got_port [$];
    logic [SZ-1:0] got_flit [$];
    logic [4:0]    prev_req = '0;

    // Inputs as the DUT sampled them at the last rising edge.
    logic          s_reset = 1'b0;
    logic          s_empty = 1'b1;
    logic [4:0]    s_ack = '0;
    logic [SZ-1:0] s_data = '0;

    always @(posedge clk) begin
        s_reset = reset;
        s_empty = fifo_empty;
        s_ack   = fifo_pop_ack;
        s_data  = fifo_data_out;
    end

    // Transaction model: a flit is in flight from its pop until release of its ack.
    bit            m_init  = 0;
    bit            m_busy  = 0;
    int            m_age   = 0;
    bit            m_acked = 0;
    int            m_dir   = 0;
    logic [SZ-1:0] m_flit  = '0;
    int            m_drops = 0;

    always @(negedge clk) begin
        logic [4:0]      exp_req;
        logic [5*SZ-1:0] exp_data;
        logic            exp_read;
        cyc++;
        if (s_reset) begin
            m_init = 1; m_busy = 0; m_flit = '0; m_drops = 0; m_acked = 0;
        end else if (m_init) begin
            if (!m_busy) begin
                if (!s_empty) begin
                    m_busy = 1; m_age = 0; m_acked = 0;
                end
            end else if (m_age == 0) begin
                m_age = 1;
            end else if (m_age == 1) begin
                m_age = 2; m_flit = s_data;
            end else if (m_age == 2) begin
                m_dir = int'(tbl[m_flit]);
                if (m_dir >= 5) begin
                    m_busy = 0;
                    if (m_drops < 255) m_drops++;
                end else begin
                    m_age = 3;
                end
            end else if (!m_acked) begin
                if (s_ack[m_dir]) m_acked = 1;
            end else if (!s_ack[m_dir]) begin
                m_busy = 0;
            end
        end

        if (m_init) begin
            exp_read = m_busy && (m_age == 0);
            exp_req  = (m_busy && m_age == 3 && !m_acked) ? (5'b1 << m_dir) : 5'b0;
            exp_data = '0;
            if (m_busy && m_age == 3) exp_data[m_dir*SZ +: SZ] = m_flit;
            chk("fifo_read", 64'(fifo_read), 64'(exp_read));
            chk("fifo_pop_req", 64'(fifo_pop_req), 64'(exp_req));
            chk("fifo_pop_data", 64'(fifo_pop_data), 64'(exp_data));
            chk("table_addr", 64'(table_addr), 64'(m_flit));
            chk("read_while_empty", 64'(fifo_read & fifo_empty), 64'(0));
            chk("req_onehot", 64'($countones(fifo_pop_req) <= 1), 64'(1));
`ifdef TX_DROP_CNT_EN
            chk("drop_count", 64'(drop_count), 64'(m_drops));
`endif
        end

        if (fifo_read) rd_cyc.push_back(cyc);
        if (fifo_pop_req != 0 && prev_req == 0) req_cyc.push_back(cyc);
        prev_req = fifo_pop_req;

        if (fifo_read && fifo_q.size() > 0) fifo_data_out = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);

        for (int k = 0; k < 5; k++) begin
            if (fifo_pop_req[k]) req_cnt[k]++; else req_cnt[k] = 0;
            if (!ack_r[k] && fifo_pop_req[k] && req_cnt[k] > ack_delay) begin
                ack_r[k] = 1'b1;
                got_port.push_back(k);
                got_flit.push_back(fifo_pop_data[k*SZ +: SZ]);
            end else if (ack_r[k] && !fifo_pop_req[k] && !hold_ack) begin
                ack_r[k] = 1'b0;
            end
        end
        fifo_pop_ack = ack_r | glitch_req;
        glitch_req   = '0;
    end

    initial begin
        int b, r, n;
        bit seen;
        for (int i = 0; i < 256; i++) tbl[i] = 3'd7;
        for (int k = 0; k < 5; k++) req_cnt[k] = 0;

        // 1 + 2: reset with a flit waiting, then delivery to East.
        tbl[8'h2A] = 3'd2;
        ack_delay  = 1;
        fifo_q.push_back(8'h2A);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("t1_reset_read", 64'(fifo_read), 64'(0));
        chk("t1_reset_req", 64'(fifo_pop_req), 64'(0));
        chk("t1_reset_taddr", 64'(table_addr), 64'(0));
`ifdef TX_DROP_CNT_EN
        chk("t1_reset_drops", 64'(drop_count), 64'(0));
`endif
        reset = 1'b0;
        @(negedge clk);
        chk("t1_first_read_lat", 64'(fifo_read), 64'(1));
        repeat (12) @(negedge clk);
        chk("t2_port", 64'(got_port.size() > 0 ? got_port[0] : -1), 64'(2));
        chk("t2_flit", 64'(got_flit.size() > 0 ? got_flit[0] : 8'hFF), 64'(8'h2A));
        chk("t2_req_latency", 64'(req_cyc.size() > 0 && rd_cyc.size() > 0 ? req_cyc[0] - rd_cyc[0] : -1), 64'(3));

        // 3: back-to-back Local then North, ack in the same cycle -> 6-cycle period.
        tbl[8'h01] = 3'd4;
        tbl[8'h02] = 3'd0;
        ack_delay  = 0;
        b = got_port.size();
        r = rd_cyc.size();
        fifo_q.push_back(8'h01);
        fifo_q.push_back(8'h02);
        repeat (20) @(negedge clk);
        chk("t3_count", 64'(got_port.size() - b), 64'(2));
        chk("t3_port0", 64'(got_port.size() > b ? got_port[b] : -1), 64'(4));
        chk("t3_flit0", 64'(got_flit.size() > b ? got_flit[b] : 8'hFF), 64'(8'h01));
        chk("t3_port1", 64'(got_port.size() > b + 1 ? got_port[b+1] : -1), 64'(0));
        chk("t3_flit1", 64'(got_flit.size() > b + 1 ? got_flit[b+1] : 8'hFF), 64'(8'h02));
        chk("t3_reads", 64'(rd_cyc.size() - r), 64'(2));
        chk("t3_period", 64'(rd_cyc.size() > r + 1 ? rd_cyc[r+1] - rd_cyc[r] : -1), 64'(6));

        // 4: West request ignores a stray North ack.
        tbl[8'h33] = 3'd3;
        ack_delay  = 8;
        b = got_port.size();
        fifo_q.push_back(8'h33);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (fifo_pop_req[3]) seen = 1;
        end
        chk("t4_req_seen", 64'(seen), 64'(1));
        glitch_req = 5'b00001;
        repeat (3) @(negedge clk);
        chk("t4_req_held", 64'(fifo_pop_req), 64'(5'b01000));
        repeat (15) @(negedge clk);
        chk("t4_port", 64'(got_port.size() > b ? got_port[b] : -1), 64'(3));
        chk("t4_flit", 64'(got_flit.size() > b ? got_flit[b] : 8'hFF), 64'(8'h33));

        // 5: invalid codes are dropped; next pop 4 cycles later.
        ack_delay = 1;
        b = got_port.size();
        r = rd_cyc.size();
        fifo_q.push_back(8'h77);
        fifo_q.push_back(8'h78);
        repeat (12) @(negedge clk);
        chk("t5_no_delivery", 64'(got_port.size() - b), 64'(0));
        chk("t5_reads", 64'(rd_cyc.size() - r), 64'(2));
        chk("t5_gap", 64'(rd_cyc.size() > r + 1 ? rd_cyc[r+1] - rd_cyc[r] : -1), 64'(4));
`ifdef TX_DROP_CNT_EN
        chk("t5_drops_2", 64'(drop_count), 64'(2));
        for (int i = 0; i < 300; i++) fifo_q.push_back(8'h80 + 8'(i % 64));
        n = 0;
        while (fifo_q.size() > 0 && n < 1400) begin
            @(negedge clk);
            n++;
        end
        repeat (8) @(negedge clk);
        chk("t5_drain", 64'(fifo_q.size()), 64'(0));
        chk("t5_drops_sat", 64'(drop_count), 64'(255));
`endif

        // 6: reset during REL with ack held high.
        tbl[8'h44] = 3'd1;
        tbl[8'h45] = 3'd1;
        ack_delay  = 0;
        hold_ack   = 1;
        fifo_q.push_back(8'h44);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ack_r[1] && fifo_pop_req == 5'b0 && fifo_pop_data[1*SZ +: SZ] == 8'h44) seen = 1;
        end
        chk("t6_in_rel", 64'(seen), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        chk("t6_req_cleared", 64'(fifo_pop_req), 64'(0));
        chk("t6_data_cleared", 64'(fifo_pop_data), 64'(0));
        chk("t6_taddr_cleared", 64'(table_addr), 64'(0));
        @(negedge clk);
        reset    = 1'b0;
        hold_ack = 0;
        r = rd_cyc.size();
        repeat (5) @(negedge clk);
        chk("t6_no_read_idle", 64'(rd_cyc.size() - r), 64'(0));
        b = got_port.size();
        fifo_q.push_back(8'h45);
        repeat (12) @(negedge clk);
        chk("t6_resume_port", 64'(got_port.size() > b ? got_port[b] : -1), 64'(1));
        chk("t6_resume_flit", 64'(got_flit.size() > b ? got_flit[b] : 8'hFF), 64'(8'h45));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
